// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares one line-oriented memory port between an instruction cache (read
//   only) and a data cache (line fill or write-back). One transaction is in
//   flight at a time. When both caches request in the same idle cycle, the
//   one that was not served last wins. The winning request is latched at the
//   grant edge, and the shared memory strobes, address and data come only from
//   that latched copy. Requesters may therefore change their inputs freely
//   while a transaction is in progress.
//
// Transaction timeline (minimum, memory answering immediately):
//   IDLE cycle  : requests sampled, grant on the closing edge
//   BUSY cycle  : mem_read or mem_write held until mem_ready is seen
//   RESP cycle  : one-cycle ready pulse to the served cache
//   then IDLE again, so back-to-back grants are one IDLE cycle apart.
//
// Ports:
//   clk          in   clock, rising-edge
//   rst_n        in   synchronous active-low reset
//   i_mem_read   in   I-cache line-fill request (held until i_mem_ready)
//   i_mem_addr   in   I-cache line address               [ADDR_W]
//   i_mem_rdata  out  line returned to I-cache           [DATA_W]
//   i_mem_ready  out  one-cycle completion pulse to I-cache
//   d_mem_read   in   D-cache line-fill request (held until d_mem_ready)
//   d_mem_write  in   D-cache write-back request (held until d_mem_ready)
//   d_mem_addr   in   D-cache line address               [ADDR_W]
//   d_mem_wdata  in   D-cache write-back line            [DATA_W]
//   d_mem_rdata  out  line returned to D-cache           [DATA_W]
//   d_mem_ready  out  one-cycle completion pulse to D-cache
//   mem_read     out  shared memory read strobe
//   mem_write    out  shared memory write strobe
//   mem_addr     out  shared memory line address         [ADDR_W]
//   mem_wdata    out  shared memory write line           [DATA_W]
//   mem_rdata    in   memory read line                   [DATA_W]
//   mem_ready    in   memory completion (only honoured while busy)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  // D-cache side
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  // shared memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  // Which requester completed most recently. Used only to break ties.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t              r_state;
  logic                r_last_grant;

  // Latched transaction. These registers drive the memory port directly.
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  // Per-requester return data and completion pulses
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_i_ready;
  logic                r_d_ready;

  // Arbitration, evaluated only in IDLE
  logic                w_i_req;
  logic                w_d_req;
  logic                w_grant_d;
  logic                w_grant_i;

  assign w_i_req = i_mem_read;
  // A D request is either a fill or a write-back. Write takes precedence if
  // both strobes are ever seen together.
  assign w_d_req = d_mem_read | d_mem_write;

  // On a tie, D wins unless D was the last one served.
  assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == GRANT_I));
  assign w_grant_i = w_i_req & ~w_grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Any in-flight transaction is dropped silently. No ready pulse is
      // produced, and the memory side simply sees its strobe withdrawn.
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_I;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state     <= S_BUSY_D;
            r_mem_addr  <= d_mem_addr;
            r_mem_wdata <= d_mem_wdata;
            r_mem_write <= d_mem_write;
            r_mem_read  <= ~d_mem_write;
          end else if (w_grant_i) begin
            // mem_wdata keeps its previous contents. It is don't-care for a read.
            r_state     <= S_BUSY_I;
            r_mem_addr  <= i_mem_addr;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
          end
        end

        S_BUSY_I: begin
          if (mem_ready) begin
            r_state      <= S_RESP_I;
            r_i_rdata    <= mem_rdata;
            r_last_grant <= GRANT_I;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_i_ready    <= 1'b1;
          end
        end

        S_BUSY_D: begin
          if (mem_ready) begin
            r_state      <= S_RESP_D;
            // A write-back must leave the previous fill data untouched.
            if (r_mem_read) begin
              r_d_rdata  <= mem_rdata;
            end
            r_last_grant <= GRANT_D;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_d_ready    <= 1'b1;
          end
        end

        // The RESP cycle ignores all requests. The served cache drops its
        // request on seeing the pulse, so the following IDLE cycle sees
        // only fresh requests.
        S_RESP_I: begin
          r_state   <= S_IDLE;
          r_i_ready <= 1'b0;
        end

        S_RESP_D: begin
          r_state   <= S_IDLE;
          r_d_ready <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_i_ready   <= 1'b0;
          r_d_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign i_mem_rdata = r_i_rdata;
  assign i_mem_ready = r_i_ready;
  assign d_mem_rdata = r_d_rdata;
  assign d_mem_ready = r_d_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Bench for mem_bus_arbiter. A transaction-level reference model tracks
// four things: who owns the memory port, who is being answered this cycle,
// the latched request, and who was served last. The model is stepped on every
// rising edge from the same inputs the DUT sees. A separate process compares
// all DUT outputs with the model on every falling edge. Directed scenarios pin
// known literal results, and randomized phases exercise the remaining
// behaviour.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_addr = '0;
  logic [DW-1:0] d_mem_wdata = '0;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  // owner/resp/last: 0 = nobody, 1 = I-cache, 2 = D-cache
  int            m_owner = 0;
  int            m_resp  = 0;
  int            m_last  = 1;
  logic          m_wr    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_irdata = '0;
  logic [DW-1:0] m_drdata = '0;

  task automatic model_step();
    if (!rst_n) begin
      m_owner = 0; m_resp = 0; m_last = 1; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    end else if (m_resp != 0) begin
      m_resp = 0;                       // answer cycle always returns to idle
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        if (m_owner == 1) m_irdata = mem_rdata;
        else if (!m_wr)   m_drdata = mem_rdata;
        m_last  = m_owner;
        m_resp  = m_owner;
        m_owner = 0;
      end
    end else begin
      if ((d_mem_read || d_mem_write) && (!i_mem_read || m_last == 1)) begin
        m_owner = 2; m_wr = d_mem_write; m_addr = d_mem_addr; m_wdata = d_mem_wdata;
      end else if (i_mem_read) begin
        m_owner = 1; m_wr = 1'b0; m_addr = i_mem_addr;
      end
    end
  endtask

  // ---------------- random stimulus ----------------
  bit          rnd_en = 1'b0;
  int unsigned p_req  = 50;
  int unsigned p_rdy  = 50;
  int unsigned rst_pm = 0;

  task automatic drive_next();
    // requesters drop a request on their ready pulse and may re-raise later
    if (m_resp == 1) i_mem_read = 1'b0;
    else if (!i_mem_read && $urandom_range(99) < p_req) i_mem_read = 1'b1;
    if ($urandom_range(1) == 1) i_mem_addr = AW'($urandom);
    if (m_resp == 2) begin
      d_mem_read = 1'b0; d_mem_write = 1'b0;
    end else if (!d_mem_read && !d_mem_write && $urandom_range(99) < p_req) begin
      if ($urandom_range(1) == 1) d_mem_write = 1'b1;
      else                        d_mem_read  = 1'b1;
    end
    if ($urandom_range(1) == 1) begin
      d_mem_addr  = AW'($urandom);
      d_mem_wdata = rnd_line();
    end
    mem_ready = ($urandom_range(99) < p_rdy);
    mem_rdata = rnd_line();
    if (rst_pm > 0) rst_n = !($urandom_range(999) < rst_pm);
  endtask

  // One clock: model sees the pre-edge inputs, then inputs change 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (rnd_en) drive_next();
  endtask

  // ---------------- per-cycle compare process ----------------
  bit chk_en   = 1'b0;
  int cnt_i    = 0;
  int cnt_d    = 0;
  int alt_bad  = 0;
  int last_src = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk1("mem_read",    mem_read,    (m_owner != 0) && !m_wr);
      chk1("mem_write",   mem_write,   (m_owner != 0) &&  m_wr);
      chkw("mem_addr",    DW'(mem_addr), DW'(m_addr));
      chkw("mem_wdata",   mem_wdata,   m_wdata);
      chk1("i_mem_ready", i_mem_ready, m_resp == 1);
      chk1("d_mem_ready", d_mem_ready, m_resp == 2);
      chkw("i_mem_rdata", i_mem_rdata, m_irdata);
      chkw("d_mem_rdata", d_mem_rdata, m_drdata);
      if (i_mem_ready === 1'b1) begin
        cnt_i++;
        if (last_src == 1) alt_bad++;
        last_src = 1;
      end
      if (d_mem_ready === 1'b1) begin
        cnt_d++;
        if (last_src == 2) alt_bad++;
        last_src = 2;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic reset_idle();
    rnd_en = 1'b0; rst_pm = 0;
    rst_n = 1'b0;
    i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    cycle();
    cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] wd;
    int rd_cyc, wr_cyc, ip, dp, ip_k, addr_bad;
    int srv[$];
    int srv_k[$];
    a5 = {16{8'hA5}};
    wd = {8{16'h1234}};

    // Reset state
    reset_idle();
    chk_en = 1'b1;
    chk1("rst mem_read", mem_read, 1'b0);
    chk1("rst mem_write", mem_write, 1'b0);
    chk1("rst i_ready", i_mem_ready, 1'b0);
    chk1("rst d_ready", d_mem_ready, 1'b0);
    chkw("rst mem_addr", DW'(mem_addr), '0);
    chkw("rst mem_wdata", mem_wdata, '0);
    chkw("rst i_rdata", i_mem_rdata, '0);
    chkw("rst d_rdata", d_mem_rdata, '0);

    // Single I read with memory answering in the 4th busy cycle
    rst_n = 1'b1; i_mem_read = 1'b1; i_mem_addr = 28'h0000100;
    rd_cyc = 0; ip = 0; dp = 0; ip_k = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (mem_read === 1'b1) rd_cyc++;
      if (i_mem_ready === 1'b1) begin ip++; ip_k = k; end
      if (d_mem_ready === 1'b1) dp++;
      if (k == 1) chkw("i read addr", DW'(mem_addr), DW'(28'h0000100));
      if (k == 4) begin mem_ready = 1'b1; mem_rdata = a5; end
      if (k == 5) begin mem_ready = 1'b0; mem_rdata = '0; i_mem_read = 1'b0; end
    end
    chki("i read strobe cycles", rd_cyc, 4);
    chki("i read ready pulses", ip, 1);
    chki("i read ready cycle", ip_k, 5);
    chki("i read d pulses", dp, 0);
    chkw("i read rdata", i_mem_rdata, a5);
    chkw("model i rdata", m_irdata, a5);

    // Simultaneous requests after reset: D, then I, then D again
    reset_idle();
    rst_n = 1'b1; i_mem_read = 1'b1; d_mem_read = 1'b1;
    i_mem_addr = 28'h0000111; d_mem_addr = 28'h0000222; mem_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      if (d_mem_ready === 1'b1) begin srv.push_back(2); srv_k.push_back(k); end
      if (i_mem_ready === 1'b1) begin srv.push_back(1); srv_k.push_back(k); end
      d_mem_read = !(d_mem_ready === 1'b1);
      i_mem_read = !(i_mem_ready === 1'b1);
    end
    chki("tie served count", srv.size(), 3);
    if (srv.size() >= 3) begin
      chki("tie first", srv[0], 2);
      chki("tie second", srv[1], 1);
      chki("tie third", srv[2], 2);
      chki("tie first cycle", srv_k[0], 2);
      chki("tie second cycle", srv_k[1], 5);
      chki("tie third cycle", srv_k[2], 8);
    end

    // D write-back while the I-cache keeps changing its address,
    // then reset while the following I read is busy
    reset_idle();
    rst_n = 1'b1;
    d_mem_write = 1'b1; d_mem_addr = 28'h0000020; d_mem_wdata = wd;
    i_mem_read = 1'b1; i_mem_addr = 28'h0000300;
    wr_cyc = 0; rd_cyc = 0; dp = 0; ip = 0; addr_bad = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (mem_write === 1'b1) begin
        wr_cyc++;
        if (mem_addr !== 28'h0000020) addr_bad++;
      end
      if (mem_read === 1'b1) rd_cyc++;
      if (d_mem_ready === 1'b1) dp++;
      if (i_mem_ready === 1'b1) ip++;
      if (k == 1) chkw("wb wdata", mem_wdata, wd);
      if (k == 6) begin
        chk1("i busy after wb", mem_read, 1'b1);
        chkw("i addr after wb", DW'(mem_addr), DW'(28'h0000305));
      end
      i_mem_addr = 28'h0000300 + AW'(k);
      if (k == 3) begin mem_ready = 1'b1; mem_rdata = {4{32'hCAFEF00D}}; end
      if (k == 4) begin mem_ready = 1'b0; d_mem_write = 1'b0; end
      if (k == 6) rst_n = 1'b0;
    end
    chki("wb write cycles", wr_cyc, 3);
    chki("wb addr unstable", addr_bad, 0);
    chki("wb read cycles", rd_cyc, 1);
    chki("wb d pulses", dp, 1);
    chkw("wb d rdata kept", d_mem_rdata, '0);
    cycle();
    if (i_mem_ready === 1'b1) ip++;
    chk1("abort mem_read", mem_read, 1'b0);
    chk1("abort mem_write", mem_write, 1'b0);
    chkw("abort mem_addr", DW'(mem_addr), '0);
    rst_n = 1'b1; d_mem_read = 1'b1; d_mem_addr = 28'h0000055;
    cycle();
    if (i_mem_ready === 1'b1) ip++;
    chk1("post abort d read", mem_read, 1'b1);
    chkw("post abort d addr", DW'(mem_addr), DW'(28'h0000055));
    chki("abort i pulses", ip, 0);

    // Random traffic with random memory latency, stray mem_ready and resets
    reset_idle();
    rst_n = 1'b1; p_req = 60; p_rdy = 35; rst_pm = 3; rnd_en = 1'b1;
    repeat (3000) cycle();

    // Saturated traffic: memory always ready, both caches always requesting
    reset_idle();
    rst_n = 1'b1; i_mem_read = 1'b1; d_mem_read = 1'b1; mem_ready = 1'b1;
    cnt_i = 0; cnt_d = 0; alt_bad = 0; last_src = 0;
    p_req = 100; p_rdy = 100; rnd_en = 1'b1;
    repeat (300) cycle();
    rnd_en = 1'b0;
    chki("sat i served", cnt_i, 50);
    chki("sat d served", cnt_d, 50);
    chki("sat alternation breaks", alt_bad, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning memory line-address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning memory line data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_mem_read  input  1  I-cache line-fill request, held until i_mem_ready.
REQ-006 SHALL have port i_mem_addr  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_mem_rdata  output  DATA_W  line returned to I-cache.
REQ-008 SHALL have port i_mem_ready  output  1  one-cycle completion pulse to I-cache.
REQ-009 SHALL have port d_mem_read  input  1  D-cache line-fill request, held until d_mem_ready.
REQ-010 SHALL have port d_mem_write  input  1  D-cache write-back request, held until d_mem_ready.
REQ-011 SHALL have port d_mem_addr  input  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_mem_wdata  input  DATA_W  D-cache write-back line.
REQ-013 SHALL have port d_mem_rdata  output  DATA_W  line returned to D-cache.
REQ-014 SHALL have port d_mem_ready  output  1  one-cycle completion pulse to D-cache.
REQ-015 SHALL have ports mem_read, mem_write  output  1 each  shared memory request strobes.
REQ-016 SHALL have ports mem_addr  output  ADDR_W and mem_wdata  output  DATA_W  shared memory address/data.
REQ-017 SHALL have ports mem_rdata  input  DATA_W and mem_ready  input  1  memory response.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-019 IDLE: only I pending -> BUSY_I; only D (read or write) pending -> BUSY_D; none -> stay IDLE.
REQ-020 IDLE, both pending: SHALL grant the requester not granted last (1-bit last_grant register); transition same edge.
REQ-021 On entering BUSY_x SHALL latch op (read/write), address, write data of the granted requester; mem_* outputs SHALL be driven from latched values only.
REQ-022 In BUSY_x SHALL hold mem_read or mem_write (exactly one) asserted continuously until mem_ready=1.
REQ-023 d_mem_read and d_mem_write both high SHALL be treated as write; requesters guarantee this never occurs.
REQ-024 BUSY_x with mem_ready=1: SHALL capture mem_rdata into x_mem_rdata register (reads only), update last_grant to x, go to RESP_x.
REQ-025 RESP_x: x_mem_ready=1 for exactly this one cycle; mem_read=mem_write=0; next state IDLE unconditionally.
REQ-026 Requests in RESP_x state SHALL be ignored; the served requester deasserts by the following IDLE cycle.
REQ-027 x_mem_rdata SHALL hold its value until the next read completion for that requester; unaffected by the other requester.
REQ-028 Minimum transaction occupancy SHALL be 3 cycles (grant edge, mem_ready cycle, RESP cycle); back-to-back grants separated by one IDLE cycle.
REQ-029 Request changes during BUSY_x (address, data, other requester) SHALL NOT affect the in-flight transaction.
REQ-030 D write-back followed by D read MAY be interleaved with one I transaction; no atomicity guaranteed.
REQ-031 mem_ready outside BUSY_x SHALL be ignored.

Reset
REQ-032 rst_n=0 at rising edge SHALL force IDLE, last_grant=I (so D wins first tie), all ready/mem strobes 0, mem_addr/mem_wdata/i_mem_rdata/d_mem_rdata 0.
REQ-033 Reset mid-transaction SHALL abort it without any ready pulse; memory tolerates withdrawn request.

Verification
REQ-034 Single I read, addr 0x0000100, memory ready after 4 cycles with 0xA5..A5 -> mem_read high 4 cycles, i_mem_ready one pulse, i_mem_rdata=0xA5..A5, d_mem_ready stays 0.
REQ-035 I and D read asserted same cycle after reset -> D served first, then I after one IDLE cycle; second tie after that -> D (alternation).
REQ-036 D write addr 0x0000020, wdata 0x1234..; I-cache changes i_mem_addr during BUSY_D -> mem_write only, mem_addr=0x0000020 stable, d_mem_ready pulse, d_mem_rdata unchanged.
REQ-037 Memory with mem_ready=1 every cycle, both requesters continuously re-requesting -> grants strictly alternate, each transaction 3 cycles, no starvation over 100 transactions.
REQ-038 rst_n low while BUSY_I -> next cycle IDLE, all strobes 0, no i_mem_ready; after reset D wins tie.
